instr_decode_stage: RTL and testbench
=====================================

// Module: instr_decode_stage
// PURPOSE
//  Pipeline ID stage: decodes the RV32I words built by compiler_pkg (addi/beq/sw...) out of IF.
//  Reads the register file (internal, 32x32), generates immediates and control, and registers
//  the result into the ID/EX boundary. Sits between instruction fetch and execute in data_path.
// PARAMETERS
//  DATA_WIDTH   32   register/immediate/PC width; only 32 is supported
//  REG_COUNT    32   architectural registers; x0 is hard-wired to zero
// PORTS
//  i_clk         in   1   clock; all state updates on rising edge
//  i_reset       in   1   synchronous, active-high reset
//  i_if_valid    in   1   i_instr/i_pc hold a real fetched instruction
//  i_instr       in   32  instruction word
//  i_pc          in   32  PC of i_instr
//  i_stall       in   1   hazard unit stall: hold ID/EX outputs
//  i_flush       in   1   branch/jump taken: next cycle presents a bubble
//  i_wb_en       in   1   writeback enable
//  i_wb_rd       in   5   writeback destination
//  i_wb_data     in   32  writeback data
//  o_valid       out  1   ID/EX holds a real instruction
//  o_pc          out  32  PC of decoded instruction
//  o_rs1_data    out  32  rs1 operand (bypassed)
//  o_rs2_data    out  32  rs2 operand (bypassed)
//  o_imm         out  32  sign-extended immediate
//  o_rs1/o_rs2   out  5   source register indices (for forwarding)
//  o_rd          out  5   destination register index
//  o_alu_op      out  4   0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASS_B
//  o_alu_src     out  1   1: ALU B = o_imm, 0: ALU B = o_rs2_data
//  o_funct3      out  3   raw funct3 (branch condition / load-store size)
//  o_reg_write   out  1   instruction writes rd (forced 0 when rd==0)
//  o_mem_read    out  1   LOAD
//  o_mem_write   out  1   STORE
//  o_branch      out  1   BRANCH
//  o_jump        out  2   0 none, 1 JAL, 2 JALR
//  o_result_src  out  2   0 ALU, 1 memory, 2 PC+4
//  o_illegal     out  1   unsupported opcode/funct combination
// BEHAVIOUR
//  - Latency: 1 cycle; decode of cycle N's i_instr appears on outputs after edge N+1.
//  - Reset (i_reset=1 at edge): all outputs 0, every register-file entry cleared to 0.
//  - Priority at each edge: reset > flush > stall > load.
//  - Flush: outputs become a bubble (o_valid=0, all control/o_illegal 0, data 0), even if stalled.
//  - Stall (no flush): all outputs hold their values; i_instr is not consumed.
//  - i_if_valid=0 or i_instr==32'h0000_0000: load a bubble; the all-zero word is the NOP, not illegal.
//  - Opcodes: OP 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011,
//    JAL 1101111, JALR 1100111, LUI 0110111 (PASS_B), AUIPC 0010111 (ADD, ALU A = PC in EX).
//  - Immediates: I, S, B (bit0=0), U (low 12 = 0), J (bit0=0); always sign-extended from bit 31.
//  - OP funct7 0100000 only legal with ADD->SUB and SRL->SRA; SLLI/SRLI/SRAI check funct7 likewise.
//  - Illegal: o_illegal=1, o_valid=1, reg_write/mem_read/mem_write/branch/jump all forced 0.
//  - Register file: write at edge when i_wb_en && i_wb_rd!=0; reads of x0 return 0.
//  - Bypass: i_wb_en && i_wb_rd==rs (rs!=0) in the same cycle -> operand = i_wb_data.
//  - Regfile writes proceed during stall and flush (WB is independent of ID).
// TESTING
//  - Reset 3 cycles, then check: all outputs 0, o_valid 0; read x5 via decode -> 0.
//  - addi x1,x1,1 = 32'h0010_8093 -> o_rd=1, o_rs1=1, o_imm=1, o_alu_op=0, o_alu_src=1, o_reg_write=1.
//  - beq x1,x2,+60 -> o_branch=1, o_imm=60, o_funct3=0, o_alu_op=1, o_reg_write=0.
//  - sw x20,-10(x30) with x30=30 -> o_imm=32'hFFFF_FFF6, o_mem_write=1, o_rs1_data=30, o_rs2=20.
//  - WB x3=0xDEAD_BEEF same cycle as add x4,x3,x0 -> o_rs1_data=0xDEAD_BEEF; WB to x0 ignored.
//  - Stall 2 cycles, then flush+stall together, then NOP word -> outputs held, then bubble; opcode 7'b1111111 -> o_illegal=1.

Source files
------------

// File: rtl/instr_decode_stage.sv
// ============================================================================
// Module  : instr_decode_stage
// Purpose : RV32I ID stage: regfile read with WB bypass, decode, ID/EX register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_decode_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_if_valid,
    input  logic [31:0]           i_instr,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic                  i_wb_en,
    input  logic [4:0]            i_wb_rd,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic [DATA_WIDTH-1:0] o_rs1_data,
    output logic [DATA_WIDTH-1:0] o_rs2_data,
    output logic [DATA_WIDTH-1:0] o_imm,
    output logic [4:0]            o_rs1,
    output logic [4:0]            o_rs2,
    output logic [4:0]            o_rd,
    output logic [3:0]            o_alu_op,
    output logic                  o_alu_src,
    output logic [2:0]            o_funct3,
    output logic                  o_reg_write,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    output logic                  o_branch,
    output logic [1:0]            o_jump,
    output logic [1:0]            o_result_src,
    output logic                  o_illegal
);

    localparam logic [6:0] c_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_LOAD   = 7'b0000011;
    localparam logic [6:0] c_STORE  = 7'b0100011;
    localparam logic [6:0] c_BRANCH = 7'b1100011;
    localparam logic [6:0] c_JAL    = 7'b1101111;
    localparam logic [6:0] c_JALR   = 7'b1100111;
    localparam logic [6:0] c_LUI    = 7'b0110111;
    localparam logic [6:0] c_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_F7_ALT = 7'b0100000;

    localparam logic [3:0] c_ALU_ADD    = 4'd0;
    localparam logic [3:0] c_ALU_SUB    = 4'd1;
    localparam logic [3:0] c_ALU_SLL    = 4'd2;
    localparam logic [3:0] c_ALU_SLT    = 4'd3;
    localparam logic [3:0] c_ALU_SLTU   = 4'd4;
    localparam logic [3:0] c_ALU_XOR    = 4'd5;
    localparam logic [3:0] c_ALU_SRL    = 4'd6;
    localparam logic [3:0] c_ALU_SRA    = 4'd7;
    localparam logic [3:0] c_ALU_OR     = 4'd8;
    localparam logic [3:0] c_ALU_AND    = 4'd9;
    localparam logic [3:0] c_ALU_PASS_B = 4'd10;

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [4:0] w_rd;
    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];
    assign w_rs1    = i_instr[19:15];
    assign w_rs2    = i_instr[24:20];
    assign w_rd     = i_instr[11:7];

    logic [DATA_WIDTH-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'h000};
    assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    // Writeback of the same cycle is forwarded so ID never reads a stale value.
    logic [DATA_WIDTH-1:0] w_rs1_data, w_rs2_data;
    assign w_rs1_data = (w_rs1 == 5'd0) ? '0 :
                        (i_wb_en && (i_wb_rd == w_rs1)) ? i_wb_data : regs_q[w_rs1];
    assign w_rs2_data = (w_rs2 == 5'd0) ? '0 :
                        (i_wb_en && (i_wb_rd == w_rs2)) ? i_wb_data : regs_q[w_rs2];

    logic                  w_legal;
    logic [DATA_WIDTH-1:0] w_imm;
    logic [3:0]            w_alu_op;
    logic                  w_alu_src;
    logic                  w_reg_write;
    logic                  w_mem_read;
    logic                  w_mem_write;
    logic                  w_branch;
    logic [1:0]            w_jump;
    logic [1:0]            w_result_src;
    logic [3:0]            w_f3_op;

    always_comb begin
        case (w_funct3)
            3'd0:    w_f3_op = c_ALU_ADD;
            3'd1:    w_f3_op = c_ALU_SLL;
            3'd2:    w_f3_op = c_ALU_SLT;
            3'd3:    w_f3_op = c_ALU_SLTU;
            3'd4:    w_f3_op = c_ALU_XOR;
            3'd5:    w_f3_op = c_ALU_SRL;
            3'd6:    w_f3_op = c_ALU_OR;
            default: w_f3_op = c_ALU_AND;
        endcase
    end

    always_comb begin
        w_legal      = 1'b1;
        w_imm        = '0;
        w_alu_op     = c_ALU_ADD;
        w_alu_src    = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_branch     = 1'b0;
        w_jump       = 2'd0;
        w_result_src = 2'd0;
        case (w_opcode)
            c_OP: begin
                w_reg_write = 1'b1;
                w_legal     = (w_funct7 == 7'd0) ||
                              ((w_funct7 == c_F7_ALT) && ((w_funct3 == 3'd0) || (w_funct3 == 3'd5)));
                if (w_funct7 == c_F7_ALT && w_funct3 == 3'd0)
                    w_alu_op = c_ALU_SUB;
                else if (w_funct7 == c_F7_ALT && w_funct3 == 3'd5)
                    w_alu_op = c_ALU_SRA;
                else
                    w_alu_op = w_f3_op;
            end
            c_OP_IMM: begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
                w_imm       = w_imm_i;
                w_alu_op    = w_f3_op;
                // funct7 sits in the upper immediate bits only for shifts
                if (w_funct3 == 3'd1)
                    w_legal = (w_funct7 == 7'd0);
                else if (w_funct3 == 3'd5) begin
                    w_legal = (w_funct7 == 7'd0) || (w_funct7 == c_F7_ALT);
                    if (w_funct7 == c_F7_ALT)
                        w_alu_op = c_ALU_SRA;
                end
            end
            c_LOAD: begin
                w_legal      = (w_funct3 != 3'd3) && (w_funct3 != 3'd6) && (w_funct3 != 3'd7);
                w_imm        = w_imm_i;
                w_alu_src    = 1'b1;
                w_mem_read   = 1'b1;
                w_reg_write  = 1'b1;
                w_result_src = 2'd1;
            end
            c_STORE: begin
                w_legal     = (w_funct3 <= 3'd2);
                w_imm       = w_imm_s;
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            c_BRANCH: begin
                w_legal  = (w_funct3 != 3'd2) && (w_funct3 != 3'd3);
                w_imm    = w_imm_b;
                w_alu_op = c_ALU_SUB;
                w_branch = 1'b1;
            end
            c_JAL: begin
                w_imm        = w_imm_j;
                w_alu_src    = 1'b1;
                w_jump       = 2'd1;
                w_reg_write  = 1'b1;
                w_result_src = 2'd2;
            end
            c_JALR: begin
                w_legal      = (w_funct3 == 3'd0);
                w_imm        = w_imm_i;
                w_alu_src    = 1'b1;
                w_jump       = 2'd2;
                w_reg_write  = 1'b1;
                w_result_src = 2'd2;
            end
            c_LUI: begin
                w_imm       = w_imm_u;
                w_alu_op    = c_ALU_PASS_B;
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
            end
            c_AUIPC: begin
                w_imm       = w_imm_u;
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
        if (!w_legal) begin
            w_imm        = '0;
            w_alu_op     = c_ALU_ADD;
            w_alu_src    = 1'b0;
            w_reg_write  = 1'b0;
            w_mem_read   = 1'b0;
            w_mem_write  = 1'b0;
            w_branch     = 1'b0;
            w_jump       = 2'd0;
            w_result_src = 2'd0;
        end
        if (w_rd == 5'd0)
            w_reg_write = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < REG_COUNT; k++)
                regs_q[k] <= '0;
        end else if (i_wb_en && (i_wb_rd != 5'd0)) begin
            regs_q[i_wb_rd] <= i_wb_data;
        end
    end

    // Flush outranks stall; a NOP or invalid fetch only bubbles when not stalled.
    logic w_clear;
    assign w_clear = i_flush || (!i_stall && (!i_if_valid || (i_instr == 32'h0000_0000)));

    always_ff @(posedge i_clk) begin
        if (i_reset || w_clear) begin
            o_valid      <= 1'b0;
            o_pc         <= '0;
            o_rs1_data   <= '0;
            o_rs2_data   <= '0;
            o_imm        <= '0;
            o_rs1        <= '0;
            o_rs2        <= '0;
            o_rd         <= '0;
            o_alu_op     <= '0;
            o_alu_src    <= 1'b0;
            o_funct3     <= '0;
            o_reg_write  <= 1'b0;
            o_mem_read   <= 1'b0;
            o_mem_write  <= 1'b0;
            o_branch     <= 1'b0;
            o_jump       <= '0;
            o_result_src <= '0;
            o_illegal    <= 1'b0;
        end else if (!i_stall) begin
            o_valid      <= 1'b1;
            o_pc         <= i_pc;
            o_rs1_data   <= w_rs1_data;
            o_rs2_data   <= w_rs2_data;
            o_imm        <= w_imm;
            o_rs1        <= w_rs1;
            o_rs2        <= w_rs2;
            o_rd         <= w_rd;
            o_alu_op     <= w_alu_op;
            o_alu_src    <= w_alu_src;
            o_funct3     <= w_funct3;
            o_reg_write  <= w_reg_write;
            o_mem_read   <= w_mem_read;
            o_mem_write  <= w_mem_write;
            o_branch     <= w_branch;
            o_jump       <= w_jump;
            o_result_src <= w_result_src;
            o_illegal    <= !w_legal;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
// ============================================================================
// Module  : tb_instr_decode_stage
// Purpose : Randomized and directed checks of instr_decode_stage against a
//           table-driven RV32I decode model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_decode_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic [2:0]  f3;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic [1:0]  jmp;
        logic [1:0]  rsrc;
        logic        ill;
    } out_t;

    // ALU op per funct3: ADD SLL SLT SLTU XOR SRL OR AND
    localparam logic [31:0] ALU_BASE = {4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifv = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;

    logic        o_valid, o_alu_src, o_reg_write, o_mem_read, o_mem_write, o_branch, o_illegal;
    logic [31:0] o_pc, o_rs1_data, o_rs2_data, o_imm;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic [3:0]  o_alu_op;
    logic [2:0]  o_funct3;
    logic [1:0]  o_jump, o_result_src;

    instr_decode_stage #(.DATA_WIDTH(32), .REG_COUNT(32)) dut (
        .i_clk(clk), .i_reset(rst), .i_if_valid(ifv), .i_instr(instr), .i_pc(pc),
        .i_stall(stall), .i_flush(flush), .i_wb_en(wb_en), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .o_valid(o_valid), .o_pc(o_pc), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
        .o_imm(o_imm), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_alu_op(o_alu_op),
        .o_alu_src(o_alu_src), .o_funct3(o_funct3), .o_reg_write(o_reg_write),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_branch(o_branch),
        .o_jump(o_jump), .o_result_src(o_result_src), .o_illegal(o_illegal)
    );

    always #5 clk = ~clk;

    out_t act;
    out_t exp_o;
    assign act = {o_valid, o_pc, o_rs1_data, o_rs2_data, o_imm, o_rs1, o_rs2, o_rd, o_alu_op,
                  o_alu_src, o_funct3, o_reg_write, o_mem_read, o_mem_write, o_branch,
                  o_jump, o_result_src, o_illegal};

    int total = 0;
    int bad = 0;
    logic chk_en = 1'b0;
    logic [31:0] mregs [32];

    task automatic check(input string name, input logic [255:0] a, input logic [255:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    function automatic logic [31:0] read_op(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_en && wb_rd == r) return wb_data;
        return mregs[r];
    endfunction

    function automatic out_t model_dec(input logic [31:0] ins, input logic [31:0] ipc,
                                       input logic [31:0] a, input logic [31:0] b);
        out_t        o;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [3:0]  base;
        logic        legal;
        logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
        f7    = ins[31:25];
        f3    = ins[14:12];
        base  = ALU_BASE[f3*4 +: 4];
        imm_i = 32'($signed(ins[31:20]));
        imm_s = 32'($signed({ins[31:25], ins[11:7]}));
        imm_b = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) << 1;
        imm_j = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) << 1;
        imm_u = {ins[31:12], 12'h000};
        o       = '0;
        o.valid = 1'b1;
        o.pc    = ipc;
        o.rs1   = ins[19:15];
        o.rs2   = ins[24:20];
        o.rd    = ins[11:7];
        o.f3    = f3;
        o.rs1d  = a;
        o.rs2d  = b;
        legal   = 1'b1;
        case (ins[6:0])
            7'h33: begin
                legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                o.alu_op = base + {3'd0, f7 == 7'h20};
                o.rw = 1'b1;
            end
            7'h13: begin
                legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                        (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
                o.alu_op = base + {3'd0, f3 == 3'd5 && f7 == 7'h20};
                o.imm = imm_i; o.alu_src = 1'b1; o.rw = 1'b1;
            end
            7'h03: begin
                legal = (f3 < 3'd6) && (f3 != 3'd3);
                o.imm = imm_i; o.alu_src = 1'b1; o.mr = 1'b1; o.rw = 1'b1; o.rsrc = 2'd1;
            end
            7'h23: begin
                legal = (f3 < 3'd3);
                o.imm = imm_s; o.alu_src = 1'b1; o.mw = 1'b1;
            end
            7'h63: begin
                legal = (f3 != 3'd2) && (f3 != 3'd3);
                o.imm = imm_b; o.alu_op = 4'd1; o.br = 1'b1;
            end
            7'h6F: begin
                o.imm = imm_j; o.alu_src = 1'b1; o.jmp = 2'd1; o.rw = 1'b1; o.rsrc = 2'd2;
            end
            7'h67: begin
                legal = (f3 == 3'd0);
                o.imm = imm_i; o.alu_src = 1'b1; o.jmp = 2'd2; o.rw = 1'b1; o.rsrc = 2'd2;
            end
            7'h37: begin
                o.imm = imm_u; o.alu_op = 4'd10; o.alu_src = 1'b1; o.rw = 1'b1;
            end
            7'h17: begin
                o.imm = imm_u; o.alu_src = 1'b1; o.rw = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            o.ill = 1'b1; o.imm = '0; o.alu_op = '0; o.alu_src = 1'b0;
            o.rw = 1'b0; o.mr = 1'b0; o.mw = 1'b0; o.br = 1'b0; o.jmp = '0; o.rsrc = '0;
        end
        if (o.rd == 5'd0) o.rw = 1'b0;
        return o;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            exp_o = '0;
            for (int i = 0; i < 32; i++) mregs[i] = '0;
        end else begin
            if (flush)
                exp_o = '0;
            else if (!stall)
                exp_o = (!ifv || instr == 32'd0) ? out_t'(0)
                      : model_dec(instr, pc, read_op(instr[19:15]), read_op(instr[24:20]));
            if (wb_en && wb_rd != 5'd0) mregs[wb_rd] = wb_data;
        end
    end

    always @(negedge clk) begin
        if (chk_en) check("model", act, exp_o);
    end

    task automatic step(input logic [31:0] ins, input logic [31:0] ipc, input logic v,
                        input logic st, input logic fl, input logic we,
                        input logic [4:0] wrd, input logic [31:0] wd);
        instr = ins; pc = ipc; ifv = v; stall = st; flush = fl;
        wb_en = we; wb_rd = wrd; wb_data = wd;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ri;
        rst = 1'b1;
        step(32'h0010_8093, 32'h4, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h55);
        chk_en = 1'b1;
        repeat (2) step(32'h0010_8093, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("reset_outputs", act, 256'd0);
        check("reset_valid", o_valid, 1'b0);
        rst = 1'b0;

        step(32'h0002_8333, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("x5_after_reset", o_rs1_data, 32'd0);
        check("x5_valid", o_valid, 1'b1);

        step(32'h0010_8093, 32'h14, 1'b1, 1'b0, 1'b0, 1'b1, 5'd30, 32'd30);
        check("addi_rd", o_rd, 5'd1);
        check("addi_rs1", o_rs1, 5'd1);
        check("addi_imm", o_imm, 32'd1);
        check("addi_aluop", o_alu_op, 4'd0);
        check("addi_alusrc", o_alu_src, 1'b1);
        check("addi_regwrite", o_reg_write, 1'b1);

        step(32'h0220_8E63, 32'h18, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'd7);
        check("beq_branch", o_branch, 1'b1);
        check("beq_imm", o_imm, 32'd60);
        check("beq_funct3", o_funct3, 3'd0);
        check("beq_aluop", o_alu_op, 4'd1);
        check("beq_regwrite", o_reg_write, 1'b0);
        check("beq_rs2_bypass", o_rs2_data, 32'd7);

        step(32'hFF4F_2B23, 32'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("sw_imm", o_imm, 32'hFFFF_FFF6);
        check("sw_memwrite", o_mem_write, 1'b1);
        check("sw_rs1_data", o_rs1_data, 32'd30);
        check("sw_rs2", o_rs2, 5'd20);

        step(32'h0001_8233, 32'h20, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF);
        check("bypass_x3", o_rs1_data, 32'hDEAD_BEEF);
        step(32'h0000_02B3, 32'h24, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h1234);
        check("wb_x0_ignored", o_rs1_data, 32'd0);
        step(32'h0001_8233, 32'h28, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("x3_committed", o_rs1_data, 32'hDEAD_BEEF);

        step(32'h0010_8093, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        step(32'hFF4F_2B23, 32'h104, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h77);
        check("stall1_pc", o_pc, 32'h100);
        step(32'hFF4F_2B23, 32'h104, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        check("stall2_rd", o_rd, 5'd1);
        check("stall2_pc", o_pc, 32'h100);
        step(32'hFF4F_2B23, 32'h104, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        check("flush_stall_valid", o_valid, 1'b0);
        check("flush_stall_pc", o_pc, 32'h0);
        step(32'h0010_8093, 32'h108, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        step(32'h0000_0000, 32'h10C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("nop_valid", o_valid, 1'b0);
        check("nop_illegal", o_illegal, 1'b0);
        step(32'h0000_007F, 32'h110, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("illegal_opc", o_illegal, 1'b1);
        check("illegal_valid", o_valid, 1'b1);
        step(32'h4000_1033, 32'h114, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("illegal_f7", o_illegal, 1'b1);
        check("illegal_rw", o_reg_write, 1'b0);
        step(32'h0003_8433, 32'h118, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("wb_during_stall", o_rs1_data, 32'h77);
        step(32'h0010_8093, 32'h11C, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("ifvalid_low", o_valid, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            logic [6:0] opcs [10];
            opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
            ri = $urandom;
            ri[6:0] = opcs[$urandom_range(0, 9)];
            if (ri[6:0] == 7'h00) ri[6:0] = 7'($urandom);
            case ($urandom_range(0, 3))
                0: ri[31:25] = 7'h00;
                1: ri[31:25] = 7'h20;
                default: ;
            endcase
            if ($urandom_range(0, 1) == 0) begin
                ri[19:15] = 5'($urandom_range(0, 7));
                ri[24:20] = 5'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 15) == 0) ri = 32'd0;
            rst = ($urandom_range(0, 299) == 0);
            step(ri, $urandom, ($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 0),
                 5'($urandom_range(0, 7)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
